// File: rtl/tx_pkg.sv
// Shared constants for the burst transmitter and the receiver correlator reference:
// timing defaults, LFSR taps, per-channel code seeds and the controller state encoding.
package tx_pkg;

    localparam int SAMPLE_DIV_DEF       = 128;
    localparam int SAMPLES_PER_CHIP_DEF = 8;
    localparam int CHIPS_PER_BURST_DEF  = 255;

    // Feedback taps on bits 0,4,5,6 realise x^8+x^6+x^5+x^4+1 for a right-shifting register
    localparam logic [7:0] LFSR_TAPS  = 8'h71;
    localparam logic [7:0] LFSR_RESET = 8'h01;

    // Every entry must stay non-zero: an all-zero LFSR never leaves the zero state
    localparam logic [7:0] CODE_SEED [16] = '{
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h5A
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_TX   = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_lfsr.sv
// 8-bit Fibonacci m-sequence generator; chip is the current bit0.
// Seed load has priority over step; both take effect on the next clock edge.
module tx_lfsr
    import tx_pkg::*;
(
    input  logic       ctx_clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic       chip
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
        end
    end

    always_ff @(posedge ctx_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_RESET;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign chip = lfsr_q[0];

endmodule

// File: rtl/tx_burst_modulator.sv
// Spread-spectrum burst transmitter: 4-phase carrier (0,+A,0,-A) flipped by an m-sequence chip.
// First strobe 2 enabled cycles after start, then one per SAMPLE_DIV enabled cycles; etx_en low freezes all.
module tx_burst_modulator
    import tx_pkg::*;
#(
    parameter int SAMPLE_DIV       = SAMPLE_DIV_DEF,
    parameter int SAMPLES_PER_CHIP = SAMPLES_PER_CHIP_DEF,
    parameter int CHIPS_PER_BURST  = CHIPS_PER_BURST_DEF
) (
    input  logic               ctx_clk,
    input  logic               rtx_rst,
    input  logic               etx_en,
    input  logic               itx_start,
    input  logic [3:0]         itx_code_id,
    input  logic [14:0]        itx_amplitude,
    output logic signed [15:0] otx_sample,
    output logic               otx_sample_valid,
    output logic               otx_busy,
    output logic               otx_done
);

    localparam int TOTAL = CHIPS_PER_BURST * SAMPLES_PER_CHIP;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SPC_W = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
    localparam int IDX_W = $clog2(TOTAL + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

    // Asynchronous assert, release aligned to ctx_clk after two flops
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    tx_state_e          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         car_q, car_d;
    logic [SPC_W-1:0]   spc_q, spc_d;
    logic [14:0]        amp_q, amp_d;
    logic signed [15:0] sample_q, sample_d;

    logic               strobe;
    logic               last;
    logic               lfsr_load;
    logic               lfsr_step;
    logic               chip;
    logic signed [15:0] amp_s;
    logic signed [15:0] base;
    logic signed [15:0] cur_sample;

    assign strobe = (state_q == ST_TX) && etx_en && (div_q == '0);
    assign last   = strobe && (idx_q == IDX_LAST);

    always_ff @(posedge ctx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (itx_start && etx_en) state_d = ST_LOAD;
            ST_LOAD: if (etx_en)              state_d = ST_TX;
            ST_TX:   if (last)                state_d = ST_DONE;
            ST_DONE: if (etx_en)              state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        otx_busy         = (state_q != ST_IDLE);
        otx_done         = (state_q == ST_DONE) && etx_en;
        otx_sample_valid = strobe;
        otx_sample       = strobe ? cur_sample : sample_q;
    end

    always_comb begin
        amp_s = signed'({1'b0, amp_q});
        case (car_q)
            2'd1:    base = amp_s;
            2'd3:    base = -amp_s;
            default: base = '0;
        endcase
        cur_sample = chip ? base : -base;
    end

    always_comb begin
        div_d     = div_q;
        idx_d     = idx_q;
        car_d     = car_q;
        spc_d     = spc_q;
        amp_d     = amp_q;
        sample_d  = sample_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (etx_en) begin
            case (state_q)
                ST_LOAD: begin
                    div_d     = '0;
                    idx_d     = '0;
                    car_d     = '0;
                    spc_d     = '0;
                    amp_d     = itx_amplitude;
                    sample_d  = '0;
                    lfsr_load = 1'b1;
                end
                ST_TX: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    if (strobe) begin
                        idx_d    = idx_q + IDX_W'(1);
                        car_d    = car_q + 2'd1;
                        // The held value drops to zero as the burst enters DONE
                        sample_d = last ? '0 : cur_sample;
                        if (spc_q == SPC_LAST) begin
                            spc_d     = '0;
                            lfsr_step = 1'b1;
                        end else begin
                            spc_d = spc_q + SPC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ctx_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            idx_q    <= '0;
            car_q    <= '0;
            spc_q    <= '0;
            amp_q    <= '0;
            sample_q <= '0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            car_q    <= car_d;
            spc_q    <= spc_d;
            amp_q    <= amp_d;
            sample_q <= sample_d;
        end
    end

    tx_lfsr u_lfsr (
        .ctx_clk (ctx_clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .seed    (CODE_SEED[itx_code_id]),
        .step    (lfsr_step),
        .chip    (chip)
    );

endmodule

// File: doc/tx_burst_modulator.md
TX_BURST_MODULATOR -- requirements
Module: tx_burst_modulator

Interface
REQ-001 Parameter SAMPLE_DIV, default 128: clocks per output sample; matches the receiver sample cadence.
REQ-002 Parameter SAMPLES_PER_CHIP, default 8: output samples per code chip, i.e. 2 carrier periods.
REQ-003 Parameter CHIPS_PER_BURST, default 255: chips per burst, one full m-sequence period.
REQ-004 ctx_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rtx_rst  in  1  asynchronous, active-low reset.
REQ-006 etx_en  in  1  enable; when low, every counter and the state machine hold.
REQ-007 itx_start  in  1  one-cycle burst request.
REQ-008 itx_code_id  in  4  code selector, 0..15; one code per receiver correlation channel.
REQ-009 itx_amplitude  in  15  unsigned carrier amplitude A.
REQ-010 otx_sample  out  16  signed modulated sample.
REQ-011 otx_sample_valid  out  1  one-cycle strobe marking a new otx_sample.
REQ-012 otx_busy  out  1  high from the start-accept cycle until the end of the DONE state.
REQ-013 otx_done  out  1  one-cycle pulse at burst end.

Function
REQ-014 The state machine SHALL have four states, IDLE, LOAD, TX and DONE, with these transitions:
- IDLE->LOAD on itx_start & etx_en.
- LOAD->TX after 1 cycle.
- TX->DONE after the last sample strobe.
- DONE->IDLE after 1 cycle.
REQ-015 itx_start SHALL be ignored in any state other than IDLE; it is not queued.
REQ-016 In LOAD the block SHALL latch itx_code_id, itx_amplitude and the seed CODE_SEED[itx_code_id], and SHALL clear the sample, carrier and chip counters.
REQ-017 The first otx_sample_valid SHALL occur in the first TX cycle, 2 enabled cycles after the start-accept edge.
REQ-018 Subsequent strobes SHALL occur every SAMPLE_DIV enabled cycles.
REQ-019 Carrier phase p = sample index mod 4; the base value SHALL be 0, +A, 0, -A for p = 0, 1, 2, 3.
REQ-020 Chip value c = LFSR bit0; otx_sample SHALL be base when c=1 and -base when c=0.
REQ-021 The negation SHALL be computed in 16-bit signed arithmetic; since A <= 32767 it never overflows, and saturation logic SHALL NOT be added.
REQ-022 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1 and SHALL advance once after every SAMPLES_PER_CHIP samples.
REQ-023 All CODE_SEED entries SHALL be non-zero; a zero seed is a package error.
REQ-024 A burst SHALL be exactly CHIPS_PER_BURST*SAMPLES_PER_CHIP strobes (2040 by default).
REQ-025 The cycle after the last strobe, otx_done SHALL pulse for 1 cycle (DONE state) and otx_sample SHALL clear to 0.
REQ-026 otx_sample SHALL hold its value between strobes.
REQ-027 With etx_en low during TX, the divider SHALL freeze and no strobe SHALL issue; on resume the stretched interval SHALL total SAMPLE_DIV enabled cycles.
REQ-028 The sample divider SHALL wrap from SAMPLE_DIV-1 to 0, and the carrier counter SHALL wrap mod 4 across chip boundaries without resetting.

Reset
REQ-029 While rtx_rst=0, the outputs SHALL be:
- otx_sample = 0
- otx_sample_valid = 0
- otx_busy = 0
- otx_done = 0
REQ-030 While rtx_rst=0, the state SHALL be IDLE, all counters 0, and the LFSR 8'h01.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately with no otx_done; the next start SHALL begin a fresh burst.
REQ-032 Reset deassertion SHALL be synchronised internally so that release occurs on a ctx_clk edge.

Structure
REQ-033 Package tx_pkg SHALL hold:
- the SAMPLE_DIV, SAMPLES_PER_CHIP and CHIPS_PER_BURST defaults;
- the LFSR tap mask;
- the 16-entry CODE_SEED table, shared with the receiver's correlator reference generation;
- the state encoding.
REQ-034 The LFSR SHALL be a separate sub-module, tx_lfsr, with ports seed load, step and chip out.

Verification
REQ-035 Code 0 (seed 8'h01), A=1000, start once: first 8 samples are 0,1000,0,-1000,0,1000,0,-1000, and all 2040 samples match the reference model; otx_done pulses once, 1 cycle after strobe 2040.
REQ-036 Strobe spacing: measured intervals are 128 cycles; first strobe is exactly 2 cycles after start.
REQ-037 itx_start pulsed at sample 500 mid-burst: it is ignored, total strobes = 2040, and the code sequence is unchanged.
REQ-038 etx_en low for 50 cycles mid-interval: that interval measures 178 cycles and sample values are unaffected.
REQ-039 rtx_rst pulled low at sample 1000: outputs are 0 immediately and no otx_done; a restart with code 5 yields the code-5 sequence from chip 0.
REQ-040 A=32767 with chip 0: the sample equals -32767 with no wrap.
